// File: rtl/pn_burst_tx.sv
// ---------------------------------------------------------------------------
// pn_burst_tx
//   Generates the pseudo-noise reference burst searched for by the UAV
//   cross-correlation receiver. A maximal-length LFSR (x^7+x^6+1) produces
//   chips that are mapped to +/-AMP. Each chip is held for SPC samples. The
//   burst repeats R = max(reps,1) times, with GAP zero samples between
//   repetitions. Samples leave over a valid/ready stream.
//
// Ports
//   clk        clock
//   rst        asynchronous reset, active-high
//   ena        clock enable; when low, all state and outputs hold
//   start      burst request, sampled in IDLE only
//   seed       LFSR initial value, captured at start (0 -> all ones)
//   reps       repetition count, captured at start (0 -> 1)
//   out_data   signed sample, two's complement
//   out_valid  out_data valid
//   out_ready  downstream accepts the sample
//   busy       high from LOAD through DONE
//   rdy        one-cycle done pulse (DONE state)
//   chip_idx   index of the current chip within the repetition
// ---------------------------------------------------------------------------
module pn_burst_tx #(
  parameter int LFSR_W  = 7,
  parameter int SEQ_LEN = 127,
  parameter int SPC     = 4,
  parameter int GAP     = 32,
  parameter int AMP     = 8192
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     start,
  input  logic [LFSR_W-1:0]        seed,
  input  logic [3:0]               reps,
  output logic signed [15:0]       out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     rdy,
  output logic [15:0]              chip_idx
);

  localparam logic signed [15:0] AMP_POS   = 16'(AMP);
  localparam logic signed [15:0] AMP_NEG   = 16'(-AMP);
  localparam logic [15:0]        SPC_LAST  = 16'(SPC - 1);
  localparam logic [15:0]        GAP_LAST  = 16'(GAP - 1);
  localparam logic [15:0]        CHIP_LAST = 16'(SEQ_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHIP,
    S_GAP,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   seed_q, seed_d;
  logic [3:0]          reps_q, reps_d;
  logic [3:0]          rep_q, rep_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [15:0]         chip_q, chip_d;
  logic [15:0]         spc_q, spc_d;
  logic [15:0]         gap_q, gap_d;

  logic [LFSR_W-1:0]   lfsr_next;
  logic                accept;

  // Chip bit to antipodal sample value.
  function automatic logic signed [15:0] map_chip(input logic chip_bit);
    return chip_bit ? AMP_POS : AMP_NEG;
  endfunction

  // Fibonacci step for x^7+x^6+1: feedback from the two top taps.
  assign lfsr_next = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_W-2]};

  // Outputs are pure functions of registered state, so an asynchronous
  // reset clears them at once and ena=0 freezes them with the state.
  assign accept = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    reps_d    = reps_q;
    rep_d     = rep_q;
    lfsr_d    = lfsr_q;
    chip_d    = chip_q;
    spc_d     = spc_q;
    gap_d     = gap_q;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    rdy       = 1'b0;
    chip_idx  = chip_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // An all-zero seed would lock the LFSR; substitute all ones.
          seed_d  = (seed == '0) ? '1 : seed;
          reps_d  = (reps == 4'd0) ? 4'd1 : reps;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        busy    = 1'b1;
        lfsr_d  = seed_q;
        chip_d  = '0;
        spc_d   = '0;
        gap_d   = '0;
        rep_d   = '0;
        state_d = S_CHIP;
      end

      S_CHIP: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = map_chip(lfsr_q[LFSR_W-1]);
        if (accept) begin
          if (spc_q == SPC_LAST) begin
            spc_d  = '0;
            lfsr_d = lfsr_next;
            if (chip_q == CHIP_LAST) begin
              if (rep_q == reps_q - 4'd1) begin
                state_d = S_DONE;
              end else begin
                rep_d = rep_q + 4'd1;
                if (GAP == 0) begin
                  // No guard interval: restart the sequence back-to-back.
                  lfsr_d = seed_q;
                  chip_d = '0;
                end else begin
                  gap_d   = '0;
                  state_d = S_GAP;
                end
              end
            end else begin
              chip_d = chip_q + 16'd1;
            end
          end else begin
            spc_d = spc_q + 16'd1;
          end
        end
      end

      S_GAP: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (accept) begin
          if (gap_q == GAP_LAST) begin
            lfsr_d  = seed_q;
            chip_d  = '0;
            spc_d   = '0;
            state_d = S_CHIP;
          end else begin
            gap_d = gap_q + 16'd1;
          end
        end
      end

      S_DONE: begin
        busy    = 1'b1;
        rdy     = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      seed_q  <= '0;
      reps_q  <= '0;
      rep_q   <= '0;
      lfsr_q  <= '0;
      chip_q  <= '0;
      spc_q   <= '0;
      gap_q   <= '0;
    end else if (ena) begin
      state_q <= state_d;
      seed_q  <= seed_d;
      reps_q  <= reps_d;
      rep_q   <= rep_d;
      lfsr_q  <= lfsr_d;
      chip_q  <= chip_d;
      spc_q   <= spc_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: tb/tb_pn_burst_tx.sv
module tb_pn_burst_tx;

  localparam int LFSR_W  = 7;
  localparam int SEQ_LEN = 127;
  localparam int SPC     = 4;
  localparam int GAP     = 32;
  localparam int AMP     = 8192;
  localparam int REP_LEN = SEQ_LEN * SPC;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               ena = 1'b1;
  logic               start = 1'b0;
  logic [LFSR_W-1:0]  seed = '0;
  logic [3:0]         reps = '0;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               busy;
  logic               rdy;
  logic [15:0]        chip_idx;

  int n_checks = 0;
  int n_errors = 0;

  int cap_q[$];
  int capi_q[$];
  int exp_q[$];
  int expi_q[$];
  int ref1_q[$];
  int ref2_q[$];

  logic               prev_stall = 1'b0;
  logic signed [15:0] prev_data = '0;
  logic [15:0]        prev_idx = '0;

  pn_burst_tx #(
    .LFSR_W(LFSR_W), .SEQ_LEN(SEQ_LEN), .SPC(SPC), .GAP(GAP), .AMP(AMP)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .seed(seed), .reps(reps),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .rdy(rdy), .chip_idx(chip_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Stream monitor: a sample leaving with valid&ready (and ena) is captured;
  // a pending sample that was not taken must still be present, unchanged.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), int'(prev_data));
        chk("hold_idx", int'(chip_idx), int'(prev_idx));
      end
      if (ena && out_valid && out_ready) begin
        cap_q.push_back(int'(out_data));
        capi_q.push_back(int'(chip_idx));
      end
      prev_stall = out_valid && !(ena && out_ready);
      prev_data  = out_data;
      prev_idx   = chip_idx;
    end
  end

  // Reference: chip n+7 = chip n XOR chip n+1 follows from the shift-left
  // LFSR with feedback q6^q5, the first 7 chips being the seed MSB first.
  task automatic build_model(input logic [LFSR_W-1:0] sd, input logic [3:0] rp);
    int c[SEQ_LEN];
    logic [LFSR_W-1:0] s;
    int r;
    s = (sd == '0) ? 7'h7F : sd;
    r = (rp == 4'd0) ? 1 : int'(rp);
    for (int i = 0; i < LFSR_W; i++) c[i] = int'(s[LFSR_W-1-i]);
    for (int n = 0; n + LFSR_W < SEQ_LEN; n++) c[n+LFSR_W] = c[n] ^ c[n+1];
    exp_q.delete();
    expi_q.delete();
    for (int rr = 0; rr < r; rr++) begin
      if (rr > 0) begin
        for (int g = 0; g < GAP; g++) begin
          exp_q.push_back(0);
          expi_q.push_back(-1);
        end
      end
      for (int k = 0; k < SEQ_LEN; k++) begin
        for (int j = 0; j < SPC; j++) begin
          exp_q.push_back(c[k] != 0 ? AMP : -AMP);
          expi_q.push_back(k);
        end
      end
    end
  endtask

  task automatic compare_stream(input string tag);
    int nmis;
    int nidx;
    int first;
    chk({tag, "_len"}, cap_q.size(), exp_q.size());
    nmis = 0;
    nidx = 0;
    first = -1;
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      if (cap_q[i] != exp_q[i]) begin
        nmis++;
        if (first < 0) first = i;
      end
      if (expi_q[i] >= 0 && capi_q[i] != expi_q[i]) nidx++;
    end
    if (first >= 0)
      $display("first differing sample %0d: got %0d want %0d", first, cap_q[first], exp_q[first]);
    chk({tag, "_data_diffs"}, nmis, 0);
    chk({tag, "_idx_diffs"}, nidx, 0);
  endtask

  // One complete burst. mode 0: out_ready high; mode 1: random out_ready.
  // ena_at/start_at (>=0) pick a loop cycle for an ena freeze / stray start.
  task automatic run_burst(input logic [LFSR_W-1:0] sd, input logic [3:0] rp,
                           input int mode, input int ena_at, input int start_at,
                           input string tag);
    bit done;
    int rdy_cnt;
    build_model(sd, rp);
    cap_q.delete();
    capi_q.delete();
    @(posedge clk); #1;
    out_ready = (mode == 0);
    seed = sd;
    reps = rp;
    start = 1'b1;
    @(negedge clk);
    chk({tag, "_idle_valid"}, int'(out_valid), 0);
    chk({tag, "_idle_busy"}, int'(busy), 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_load_busy"}, int'(busy), 1);
    chk({tag, "_load_valid"}, int'(out_valid), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_first_valid"}, int'(out_valid), 1);
    chk({tag, "_first_data"}, int'(out_data), exp_q[0]);

    done = 1'b0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      @(posedge clk); #1;
      if (mode != 0) out_ready = 1'($urandom_range(0, 1));
      if (ena_at >= 0 && cyc == ena_at) ena = 1'b0;
      if (ena_at >= 0 && cyc == ena_at + 10) ena = 1'b1;
      if (start_at >= 0 && cyc == start_at) begin
        start = 1'b1;
        seed = ~sd;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (ena_at >= 0 && cyc > ena_at && cyc < ena_at + 10) begin
        chk({tag, "_frozen_busy"}, int'(busy), 1);
        chk({tag, "_frozen_rdy"}, int'(rdy), 0);
      end
      if (start_at >= 0 && cyc == start_at + 1)
        chk({tag, "_stray_start_busy"}, int'(busy), 1);
      if (rdy) begin
        done = 1'b1;
        chk({tag, "_done_valid"}, int'(out_valid), 0);
      end
    end
    chk({tag, "_reached_done"}, int'(done), 1);

    rdy_cnt = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (rdy) rdy_cnt++;
    end
    chk({tag, "_rdy_pulse"}, rdy_cnt, 1);
    chk({tag, "_idle_after"}, int'(busy), 0);
    compare_stream(tag);
  endtask

  initial begin
    int errs;
    // Reset defaults while held from time zero.
    #2;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rdy", int'(rdy), 0);
    chk("rst_idx", int'(chip_idx), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Chip sequence, one repetition, ready tied high.
    run_burst(7'h7F, 4'd1, 0, -1, -1, "seq");
    ref1_q = cap_q;
    for (int k = 0; k < 14 && k * SPC < cap_q.size(); k++)
      chk($sformatf("seq_chip%0d", k), cap_q[k*SPC], (k >= 7 && k <= 12) ? -AMP : AMP);

    // Two repetitions with guard gap.
    run_burst(7'h7F, 4'd2, 0, -1, -1, "full");
    ref2_q = cap_q;
    chk("full_count", cap_q.size(), 2 * REP_LEN + GAP);
    if (cap_q.size() == 2 * REP_LEN + GAP) begin
      errs = 0;
      for (int i = REP_LEN; i < REP_LEN + GAP; i++) if (cap_q[i] != 0) errs++;
      chk("full_gap_zero", errs, 0);
      errs = 0;
      for (int i = 0; i < REP_LEN; i++) if (cap_q[i] != cap_q[REP_LEN+GAP+i]) errs++;
      chk("full_rep_identical", errs, 0);
    end

    // Backpressure with random ready: same accepted stream.
    run_burst(7'h7F, 4'd2, 1, -1, -1, "bp");
    chk("bp_same_len", cap_q.size(), ref2_q.size());
    errs = 0;
    for (int i = 0; i < cap_q.size() && i < ref2_q.size(); i++) if (cap_q[i] != ref2_q[i]) errs++;
    chk("bp_same_stream", errs, 0);

    // Seed 0 behaves as all ones; reps 0 behaves as one.
    run_burst(7'h00, 4'd1, 0, -1, -1, "seed0");
    errs = 0;
    for (int i = 0; i < cap_q.size() && i < ref1_q.size(); i++) if (cap_q[i] != ref1_q[i]) errs++;
    chk("seed0_vs_ones", errs, 0);
    run_burst(7'h7F, 4'd0, 0, -1, -1, "reps0");

    // Stray start mid-burst, ena freeze mid-chip, random ready.
    run_burst(7'h35, 4'd2, 1, 100, 60, "gate");

    // Reset in the middle of a burst clears everything without a clock edge.
    @(posedge clk); #1;
    out_ready = 1'b1;
    seed = 7'h2B;
    reps = 4'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_data", int'(out_data), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_rdy", int'(rdy), 0);
    chk("midrst_idx", int'(chip_idx), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_stays_idle", int'(busy), 0);

    // Random seeds and repetition counts under random backpressure.
    for (int t = 0; t < 3; t++) begin
      run_burst(7'($urandom_range(0, 127)), 4'($urandom_range(0, 3)), 1, -1, -1,
                $sformatf("rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
